// File: rtl/busca_instrucao_if.sv
// Fetch-stage bus: decode handshake (stall/desvio/alvo), the memory read
// data coming in, and the tagged instruction going out to decode.
// master = the fetch stage, slave = its surroundings (memory + decode).
interface busca_instrucao_if #(
    parameter int LARGURA_END   = 10,
    parameter int LARGURA_INSTR = 32
);
    logic                     stall;
    logic                     desvio;
    logic [LARGURA_END-1:0]   alvo;
    logic [LARGURA_INSTR-1:0] instrucao_mem;
    logic [LARGURA_END-1:0]   endereco;
    logic [LARGURA_INSTR-1:0] instrucao;
    logic [LARGURA_END-1:0]   pc_instrucao;
    logic [LARGURA_END-1:0]   pc_mais1;
    logic                     valida;
    logic                     parado;

    modport master (
        input  stall, desvio, alvo, instrucao_mem,
        output endereco, instrucao, pc_instrucao, pc_mais1, valida, parado
    );

    modport slave (
        output stall, desvio, alvo, instrucao_mem,
        input  endereco, instrucao, pc_instrucao, pc_mais1, valida, parado
    );
endinterface

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage in front of a memory with a registered 1-cycle
// read. Owns the PC, tags each returned word with the address it came from
// and a valid bit, holds the output on stall and inserts one bubble on a
// branch redirect.
// Optional build macro PARADA_EN: halt fetching after a zero instruction
// word has been presented; only Rst leaves the halted state.
module busca_instrucao #(
    parameter int                     LARGURA_END   = 10,
    parameter int                     LARGURA_INSTR = 32,
    parameter logic [LARGURA_END-1:0] PC_INICIAL    = '0
) (
    input  logic                Clk,
    input  logic                Rst,
    busca_instrucao_if.master   bus
);

    // Address currently presented to the memory, and the address whose data
    // the memory is returning this cycle.
    logic [LARGURA_END-1:0]   pc;
    logic [LARGURA_END-1:0]   pc_ant;
    logic                     val_ant;

    // Copy of the outputs taken on a stall; the memory word read during the
    // stall is thrown away because the same address is re-presented.
    logic                     usa_buf;
    logic [LARGURA_INSTR-1:0] buf_instr;
    logic [LARGURA_END-1:0]   buf_pc;
    logic                     buf_val;

    logic [LARGURA_INSTR-1:0] instr_sel;
    logic [LARGURA_END-1:0]   pc_sel;
    logic                     val_sel;
    logic                     congela;

`ifdef PARADA_EN
    typedef enum logic {BUSCA, PARADO} estado_t;

    estado_t estado;
    estado_t prox_estado;

    // Halt FSM state register
    always_ff @(posedge Clk) begin
        if (Rst) estado <= BUSCA;
        else     estado <= prox_estado;
    end

    // Halt FSM next state: a zero word accepted by decode stops fetching
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned; otherwise a latch would be inferred.
        prox_estado = estado;
        if (estado == BUSCA && bus.valida && bus.instrucao == '0 &&
            !bus.stall && !bus.desvio)
            prox_estado = PARADO;
    end

    // Halt FSM outputs: freeze the datapath and report the halt
    always_comb begin
        congela    = (estado == PARADO);
        bus.parado = congela;
    end
`else
    assign congela    = 1'b0;
    assign bus.parado = 1'b0;
`endif

    // PC, tag pipeline and stall buffer
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking ones would make the result depend
    // on statement order and diverge from the synthesized flops.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc        <= PC_INICIAL;
            pc_ant    <= PC_INICIAL;
            val_ant   <= 1'b0;
            usa_buf   <= 1'b0;
            buf_instr <= '0;
            buf_pc    <= '0;
            buf_val   <= 1'b0;
        end else if (!congela) begin
            if (bus.desvio) begin
                // Redirect wins over stall; the current output counts as
                // consumed and the next cycle is a bubble.
                pc      <= bus.alvo;
                pc_ant  <= pc;
                val_ant <= 1'b0;
                usa_buf <= 1'b0;
            end else if (bus.stall) begin
                // Hold the address; park the current outputs in the buffer.
                val_ant   <= 1'b1;
                usa_buf   <= 1'b1;
                buf_instr <= instr_sel;
                buf_pc    <= pc_sel;
                buf_val   <= val_sel;
            end else begin
                pc      <= pc + 1'b1;
                pc_ant  <= pc;
                val_ant <= 1'b1;
                usa_buf <= 1'b0;
            end
        end
    end

    // Output source: stall buffer while a stall is being held, memory otherwise
    always_comb begin
        instr_sel = bus.instrucao_mem;
        pc_sel    = pc_ant;
        val_sel   = val_ant;
        if (usa_buf) begin
            instr_sel = buf_instr;
            pc_sel    = buf_pc;
            val_sel   = buf_val;
        end
    end

    assign bus.endereco     = pc;
    assign bus.instrucao    = instr_sel;
    assign bus.pc_instrucao = pc_sel;
    assign bus.pc_mais1     = pc_sel + 1'b1;
    assign bus.valida       = val_sel & ~congela;

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: models the registered instruction memory,
// queues the expected decode-side output of every cycle as stimulus is
// planned, and pops/compares one entry per cycle on the falling edge.
module tb_busca_instrucao;

    localparam int LE = 10;
    localparam int LI = 32;
`ifdef PARADA_EN
    localparam bit PARADA = 1'b1;
`else
    localparam bit PARADA = 1'b0;
`endif

    typedef struct {
        bit          valid;
        logic [31:0] instr;
        logic [9:0]  pc;
        logic [9:0]  pc1;
    } saida_t;

    logic        Clk;
    logic        Rst;
    logic [31:0] mem [1024];
    saida_t      sb [$];
    saida_t      exp_s;
    int          checks;
    int          errors;

    busca_instrucao_if #(.LARGURA_END(LE), .LARGURA_INSTR(LI)) bus ();

    busca_instrucao #(.LARGURA_END(LE), .LARGURA_INSTR(LI), .PC_INICIAL(10'd0)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Instruction memory with a registered 1-cycle read
    always @(posedge Clk) bus.instrucao_mem <= mem[bus.endereco];

    function automatic void espera_busca(input logic [9:0] p);
        saida_t s;
        s.valid = 1'b1;
        s.instr = mem[p];
        s.pc    = p;
        s.pc1   = p + 10'd1;
        sb.push_back(s);
    endfunction

    function automatic void espera_bolha();
        saida_t s;
        s.valid = 1'b0;
        s.instr = '0;
        s.pc    = '0;
        s.pc1   = '0;
        sb.push_back(s);
    endfunction

    function automatic saida_t proxima();
        saida_t s;
        if (sb.size() == 0) begin
            s.valid = 1'bx;
            s.instr = 'x;
            s.pc    = 'x;
            s.pc1   = 'x;
        end else begin
            s = sb.pop_front();
        end
        return s;
    endfunction

    task automatic test_reset();
        Rst = 1'b1; bus.stall = 1'b0; bus.desvio = 1'b0; bus.alvo = '0;
        espera_bolha();
        for (int p = 0; p < 4; p++) espera_busca(10'(p));
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            exp_s = proxima();
            checks++;
            if (bus.valida !== exp_s.valid || (exp_s.valid &&
                {bus.instrucao, bus.pc_instrucao, bus.pc_mais1} !== {exp_s.instr, exp_s.pc, exp_s.pc1})) begin
                errors++;
                $display("FAIL reset k=%0d got valida=%b instr=%h pc=%0d pc1=%0d want valida=%b instr=%h pc=%0d pc1=%0d",
                         k, bus.valida, bus.instrucao, bus.pc_instrucao, bus.pc_mais1,
                         exp_s.valid, exp_s.instr, exp_s.pc, exp_s.pc1);
            end
            if (k == 0) begin
                checks++;
                if (bus.endereco !== 10'd0 || bus.parado !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state got endereco=%0d parado=%b want endereco=0 parado=0",
                             bus.endereco, bus.parado);
                end
            end
            Rst = 1'b0;
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) espera_busca(10'd4);
        for (int p = 5; p < 8; p++) espera_busca(10'(p));
        for (int k = 0; k < 7; k++) begin
            @(negedge Clk);
            exp_s = proxima();
            checks++;
            if (bus.valida !== exp_s.valid || (exp_s.valid &&
                {bus.instrucao, bus.pc_instrucao, bus.pc_mais1} !== {exp_s.instr, exp_s.pc, exp_s.pc1})) begin
                errors++;
                $display("FAIL stall k=%0d got valida=%b instr=%h pc=%0d pc1=%0d want valida=%b instr=%h pc=%0d pc1=%0d",
                         k, bus.valida, bus.instrucao, bus.pc_instrucao, bus.pc_mais1,
                         exp_s.valid, exp_s.instr, exp_s.pc, exp_s.pc1);
            end
            bus.stall = (k < 3);
        end
    endtask

    task automatic test_branch();
        Rst = 1'b1;
        espera_bolha();
        for (int p = 0; p < 3; p++) espera_busca(10'(p));
        espera_bolha();
        for (int p = 8; p < 11; p++) espera_busca(10'(p));
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            exp_s = proxima();
            checks++;
            if (bus.valida !== exp_s.valid || (exp_s.valid &&
                {bus.instrucao, bus.pc_instrucao, bus.pc_mais1} !== {exp_s.instr, exp_s.pc, exp_s.pc1})) begin
                errors++;
                $display("FAIL branch k=%0d got valida=%b instr=%h pc=%0d pc1=%0d want valida=%b instr=%h pc=%0d pc1=%0d",
                         k, bus.valida, bus.instrucao, bus.pc_instrucao, bus.pc_mais1,
                         exp_s.valid, exp_s.instr, exp_s.pc, exp_s.pc1);
            end
            Rst        = 1'b0;
            bus.desvio = (k == 3);
            bus.alvo   = 10'd8;
        end
    endtask

    task automatic test_stall_desvio_wrap();
        espera_busca(10'd11);
        espera_bolha();
        espera_busca(10'd1023);
        espera_busca(10'd0);
        espera_busca(10'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            exp_s = proxima();
            checks++;
            if (bus.valida !== exp_s.valid || (exp_s.valid &&
                {bus.instrucao, bus.pc_instrucao, bus.pc_mais1} !== {exp_s.instr, exp_s.pc, exp_s.pc1})) begin
                errors++;
                $display("FAIL stall_desvio k=%0d got valida=%b instr=%h pc=%0d pc1=%0d want valida=%b instr=%h pc=%0d pc1=%0d",
                         k, bus.valida, bus.instrucao, bus.pc_instrucao, bus.pc_mais1,
                         exp_s.valid, exp_s.instr, exp_s.pc, exp_s.pc1);
            end
            bus.stall  = (k == 0);
            bus.desvio = (k == 0);
            bus.alvo   = 10'h3FF;
        end
    endtask

    task automatic test_reset_in_stall();
        espera_busca(10'd2);
        espera_busca(10'd2);
        espera_bolha();
        espera_busca(10'd0);
        espera_busca(10'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            exp_s = proxima();
            checks++;
            if (bus.valida !== exp_s.valid || (exp_s.valid &&
                {bus.instrucao, bus.pc_instrucao, bus.pc_mais1} !== {exp_s.instr, exp_s.pc, exp_s.pc1})) begin
                errors++;
                $display("FAIL reset_in_stall k=%0d got valida=%b instr=%h pc=%0d pc1=%0d want valida=%b instr=%h pc=%0d pc1=%0d",
                         k, bus.valida, bus.instrucao, bus.pc_instrucao, bus.pc_mais1,
                         exp_s.valid, exp_s.instr, exp_s.pc, exp_s.pc1);
            end
            bus.stall = (k < 2);
            Rst       = (k == 1);
        end
    endtask

    task automatic test_parada();
        logic exp_parado;
        for (int p = 2; p < 27; p++) espera_busca(10'(p));
        for (int p = 27; p < 33; p++) begin
            if (PARADA) espera_bolha();
            else        espera_busca(10'(p));
        end
        for (int k = 0; k < 31; k++) begin
            @(negedge Clk);
            exp_s = proxima();
            checks++;
            if (bus.valida !== exp_s.valid || (exp_s.valid &&
                {bus.instrucao, bus.pc_instrucao, bus.pc_mais1} !== {exp_s.instr, exp_s.pc, exp_s.pc1})) begin
                errors++;
                $display("FAIL parada k=%0d got valida=%b instr=%h pc=%0d pc1=%0d want valida=%b instr=%h pc=%0d pc1=%0d",
                         k, bus.valida, bus.instrucao, bus.pc_instrucao, bus.pc_mais1,
                         exp_s.valid, exp_s.instr, exp_s.pc, exp_s.pc1);
            end
            exp_parado = PARADA && (k >= 25);
            checks++;
            if (bus.parado !== exp_parado) begin
                errors++;
                $display("FAIL parado k=%0d got %b want %b", k, bus.parado, exp_parado);
            end
            // In the halted state a redirect and a stall must both be ignored.
            bus.desvio = PARADA && (k == 26);
            bus.stall  = PARADA && (k == 28);
            bus.alvo   = 10'd5;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[0]  = 32'h23E0_1500;
        mem[1]  = 32'h23E1_1501;
        mem[4]  = 32'h1C01_22B2;
        mem[26] = 32'h0000_0000;

        test_reset();
        test_stall();
        test_branch();
        test_stall_desvio_wrap();
        test_reset_in_stall();
        test_parada();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no end of run want $finish before 100000");
        $fatal(1);
    end

endmodule
